adc_spi_multich_model: RTL and testbench

Parametrised, synthesizable model of an ADC128S-style SPI A/D converter for the guitar_fx system bench. It serves up to eight channels, each with its own programmable sample generator (hold, decrement, increment, triangle). Reads follow the real part's pipelining: each frame returns the channel addressed in the previous frame. A host-side config port lets the testbench preload per-channel values, steps and modes.

---
 rtl/adc_model_pkg.sv | 20 ++
 rtl/spi_frame_slave.sv | 85 ++++++++
 rtl/adc_spi_multich_model.sv | 109 ++++++++++
 tb/tb_adc_spi_multich_model.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_model_pkg.sv
// Shared types and constants for the multi-channel SPI ADC model.
package adc_model_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        DEC  = 2'd1,
        INC  = 2'd2,
        TRI  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } frame_state_t;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CH_LSB     = 11;

endpackage

// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave: pin synchronizers, edge detect, frame FSM and shifters.
module spi_frame_slave
    import adc_model_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ss_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic [15:0] tx_load,
    output logic        miso,
    output logic [15:0] rx,
    output logic        frame_done
);

    logic [2:0]   ss_q;
    logic [2:0]   sclk_q;
    logic [1:0]   mosi_q;
    logic [15:0]  tx;
    logic [4:0]   cnt;
    frame_state_t state;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q   <= '1;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            ss_q   <= {ss_q[1:0], ss_n};
            sclk_q <= {sclk_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign ss_fall   =  ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] &  ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
    assign mosi_s    = mosi_q[1];

    // Combinational so the top registers rdy on the same edge the rise is seen.
    assign frame_done = (state == SHIFT) && ss_rise && (cnt == 5'(FRAME_BITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tx    <= '0;
            rx    <= '0;
            cnt   <= '0;
            miso  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state <= SHIFT;
                        tx    <= tx_load;
                        miso  <= tx_load[15];
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        miso  <= 1'b0;
                        state <= (cnt == 5'(FRAME_BITS)) ? DONE : IDLE;
                    end else begin
                        if (sclk_rise) begin
                            rx <= {rx[14:0], mosi_s};
                            if (cnt != 5'd31)
                                cnt <= cnt + 5'd1;
                        end
                        if (sclk_fall) begin
                            tx   <= {tx[14:0], 1'b0};
                            miso <= tx[14];
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/adc_spi_multich_model.sv
// ADC128S-style multi-channel SPI ADC model with per-channel sample generators.
module adc_spi_multich_model
    import adc_model_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned RES      = 12,
    parameter int unsigned STEP_DEF = 'h111,
    parameter mode_t       MODE_DEF = DEC
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           SS_n,
    input  logic           SCLK,
    input  logic           MOSI,
    output logic           MISO,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_ch,
    input  logic [1:0]     cfg_mode,
    input  logic [RES-1:0] cfg_value,
    input  logic [RES-1:0] cfg_step,
    output logic           rdy,
    output logic           err,
    output logic [2:0]     cur_ch
);

    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

    logic [RES-1:0]    value [NUM_CH];
    logic [RES-1:0]    step  [NUM_CH];
    mode_t             ch_mode [NUM_CH];
    logic [NUM_CH-1:0] dir;
    logic [2:0]        ptr;
    logic [15:0]       rx;
    logic [15:0]       tx_load;
    logic [RES-1:0]    sel_val;
    logic              frame_done;

    spi_frame_slave u_slave (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n       (SS_n),
        .sclk       (SCLK),
        .mosi       (MOSI),
        .tx_load    (tx_load),
        .miso       (MISO),
        .rx         (rx),
        .frame_done (frame_done)
    );

    // Pointers beyond NUM_CH match no channel and read back as zero.
    always_comb begin
        sel_val = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (ptr == 3'(i))
                sel_val = value[i];
        tx_load = '0;
        tx_load[RES-1:0] = sel_val;
    end

    // Returns {dir, value}; dir 0 = counting up.
    function automatic logic [RES:0] mode_next(input logic [RES-1:0] v, input logic [RES-1:0] s,
                                               input mode_t m, input logic d);
        logic [RES:0] sum;
        sum = {1'b0, v} + {1'b0, s};
        case (m)
            HOLD:    mode_next = {d, v};
            DEC:     mode_next = {d, v - s};
            INC:     mode_next = {d, v + s};
            default: begin
                if (!d)
                    mode_next = sum[RES] ? {1'b1, {RES{1'b1}}} : {1'b0, sum[RES-1:0]};
                else
                    mode_next = (v < s) ? {1'b0, {RES{1'b0}}} : {1'b1, v - s};
            end
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                value[i]   <= '1;
                step[i]    <= RES'(STEP_DEF);
                ch_mode[i] <= MODE_DEF;
            end
            dir <= '0;
            ptr <= '0;
            rdy <= 1'b0;
            err <= 1'b0;
        end else begin
            rdy <= frame_done;
            err <= frame_done && ({1'b0, rx[CH_LSB +: 3]} >= NUM_CH_W);
            if (frame_done)
                ptr <= rx[CH_LSB +: 3];
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (frame_done && ptr == 3'(i))
                    {dir[i], value[i]} <= mode_next(value[i], step[i], ch_mode[i], dir[i]);
                if (cfg_we && cfg_ch == 3'(i)) begin
                    value[i]   <= cfg_value;
                    step[i]    <= cfg_step;
                    ch_mode[i] <= mode_t'(cfg_mode);
                    dir[i]     <= 1'b0;
                end
            end
        end
    end

    assign cur_ch = ptr;

endmodule

// File: tb/tb_adc_spi_multich_model.sv
// Directed plus randomized bench for adc_spi_multich_model against an arithmetic channel model.
module tb_adc_spi_multich_model;

    localparam int RES  = 12;
    localparam int M    = 1 << RES;
    localparam int HALF = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      ss_n_v;
    logic            sclk, mosi;
    logic [1:0]      miso_v, rdy_v, err_v, cfg_we_v;
    logic [2:0]      cur0, cur1;
    logic [2:0]      cfg_ch;
    logic [1:0]      cfg_mode;
    logic [RES-1:0]  cfg_value, cfg_step;

    int checks = 0;
    int errors = 0;
    int rdy_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};

    int m_val  [2][8];
    int m_step [2][8];
    int m_mode [2][8];
    bit m_dir  [2][8];
    int m_ptr  [2];
    logic [15:0] last_resp;

    always #5 clk = ~clk;

    adc_spi_multich_model dut0 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n_v[0]), .SCLK(sclk), .MOSI(mosi), .MISO(miso_v[0]),
        .cfg_we(cfg_we_v[0]), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_value(cfg_value),
        .cfg_step(cfg_step), .rdy(rdy_v[0]), .err(err_v[0]), .cur_ch(cur0)
    );

    adc_spi_multich_model #(.NUM_CH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n_v[1]), .SCLK(sclk), .MOSI(mosi), .MISO(miso_v[1]),
        .cfg_we(cfg_we_v[1]), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_value(cfg_value),
        .cfg_step(cfg_step), .rdy(rdy_v[1]), .err(err_v[1]), .cur_ch(cur1)
    );

    always @(posedge clk) begin
        if (rdy_v[0]) rdy_cnt[0] <= rdy_cnt[0] + 1;
        if (rdy_v[1]) rdy_cnt[1] <= rdy_cnt[1] + 1;
        if (err_v[0]) err_cnt[0] <= err_cnt[0] + 1;
        if (err_v[1]) err_cnt[1] <= err_cnt[1] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            for (int c = 0; c < 8; c++) begin
                m_val[d][c]  = M - 1;
                m_step[d][c] = 'h111;
                m_mode[d][c] = 1;
                m_dir[d][c]  = 1'b0;
            end
        end
    endfunction

    function automatic void model_cfg(input int d, input int ch, input int md, input int v, input int s);
        if (ch < nch(d)) begin
            m_val[d][ch]  = v;
            m_step[d][ch] = s;
            m_mode[d][ch] = md;
            m_dir[d][ch]  = 1'b0;
        end
    endfunction

    // Sample generator rules: 0 hold, 1 dec, 2 inc, 3 triangle clamped at 0 and max.
    function automatic void model_step(input int d, input int ch);
        int v = m_val[d][ch];
        int s = m_step[d][ch];
        case (m_mode[d][ch])
            0: ;
            1: v = (v - s + M) % M;
            2: v = (v + s) % M;
            default: begin
                if (!m_dir[d][ch]) begin
                    if (v + s > M - 1) begin v = M - 1; m_dir[d][ch] = 1'b1; end
                    else v = v + s;
                end else begin
                    if (v < s) begin v = 0; m_dir[d][ch] = 1'b0; end
                    else v = v - s;
                end
            end
        endcase
        m_val[d][ch] = v;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input int d, input int ch, input int md, input int v, input int s);
        @(negedge clk);
        cfg_ch    = 3'(ch);
        cfg_mode  = 2'(md);
        cfg_value = RES'(v);
        cfg_step  = RES'(s);
        cfg_we_v[d] = 1'b1;
        @(negedge clk);
        cfg_we_v[d] = 1'b0;
        model_cfg(d, ch, md, v, s);
    endtask

    task automatic frame(input int d, input logic [15:0] cmd, input int nbits, input bit collide);
        logic [15:0] resp = '0;
        logic [15:0] exp_resp;
        int r0 = rdy_cnt[d];
        int e0 = err_cnt[d];
        bit full = (nbits == 16);
        bit exp_err = 1'b0;
        exp_resp = (m_ptr[d] < nch(d)) ? 16'(m_val[d][m_ptr[d]]) : 16'h0000;
        ss_n_v[d] = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = cmd[15-i];
            wait_clk(HALF);
            resp[15-i] = miso_v[d];
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        ss_n_v[d] = 1'b1;
        if (full) begin
            if (m_ptr[d] < nch(d)) model_step(d, m_ptr[d]);
            m_ptr[d] = int'(cmd[13:11]);
            exp_err  = (m_ptr[d] >= nch(d));
        end
        wait_clk(2);
        if (collide) begin
            cfg_ch = 3'd0; cfg_mode = 2'd0; cfg_value = RES'('hABC); cfg_step = RES'(1);
            cfg_we_v[d] = 1'b1;
        end
        wait_clk(1);
        if (collide) begin
            cfg_we_v[d] = 1'b0;
            model_cfg(d, 0, 0, 'hABC, 1);
        end
        check("rdy_at_3clk", 32'(rdy_v[d]), 32'(full));
        check("err_with_rdy", 32'(err_v[d]), 32'(exp_err));
        check("cur_ch", 32'(d == 0 ? cur0 : cur1), 32'(m_ptr[d]));
        wait_clk(1);
        check("rdy_one_cycle", 32'(rdy_v[d]), 32'd0);
        check("miso_idle", 32'(miso_v[d]), 32'd0);
        check("rdy_count", 32'(rdy_cnt[d] - r0), 32'(full));
        check("err_count", 32'(err_cnt[d] - e0), 32'(exp_err));
        if (full) check("resp", 32'(resp), 32'(exp_resp));
        else      check("resp_partial", 32'(resp >> (16 - nbits)), 32'(exp_resp >> (16 - nbits)));
        last_resp = resp;
        wait_clk(4);
    endtask

    initial begin
        int r0;
        rst_n = 1'b0; ss_n_v = 2'b11; sclk = 1'b0; mosi = 1'b0; cfg_we_v = 2'b00;
        cfg_ch = '0; cfg_mode = '0; cfg_value = '0; cfg_step = '0;
        model_reset();
        wait_clk(3);
        check("reset_miso", 32'(miso_v), 32'd0);
        check("reset_rdy", 32'(rdy_v), 32'd0);
        check("reset_err", 32'(err_v), 32'd0);
        check("reset_cur_ch", 32'(cur0), 32'd0);
        rst_n = 1'b1;
        wait_clk(3);

        frame(0, 16'h0000, 16, 0);
        check("default_first", 32'(last_resp), 32'h0FFF);
        frame(0, 16'h0000, 16, 0);
        check("default_second", 32'(last_resp), 32'h0EEE);

        cfg_write(0, 3, 0, 'h123, 1);
        cfg_write(0, 5, 0, 'h456, 1);
        frame(0, 16'(3 << 11), 16, 0);
        frame(0, 16'(5 << 11), 16, 0);
        check("pipe_ch3", 32'(last_resp), 32'h0123);
        frame(0, 16'h0000, 16, 0);
        check("pipe_ch5", 32'(last_resp), 32'h0456);

        cfg_write(0, 1, 1, 'h005, 'h010);
        for (int i = 0; i < 3; i++) frame(0, 16'(1 << 11), 16, 0);
        check("dec_wrap", 32'(last_resp), 32'h0FF5);

        cfg_write(0, 2, 3, 'hFF0, 'h020);
        for (int i = 0; i < 5; i++) frame(0, 16'(2 << 11), 16, 0);
        check("tri_down", 32'(last_resp), 32'h0FBF);

        frame(0, 16'(2 << 11), 8, 0);
        frame(0, 16'(2 << 11), 16, 0);

        cfg_write(1, 6, 0, 'h777, 1);
        frame(1, 16'(6 << 11), 16, 0);
        frame(1, 16'h0000, 16, 0);
        check("oob_zero", 32'(last_resp), 32'h0000);

        frame(0, 16'h0000, 16, 0);
        frame(0, 16'h0000, 16, 1);
        frame(0, 16'h0000, 16, 0);
        check("cfg_wins", 32'(last_resp), 32'h0ABC);

        for (int i = 0; i < 20; i++) begin
            int d = (i % 5 == 4) ? 1 : 0;
            if ($urandom_range(0, 3) == 0)
                cfg_write(d, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)));
            frame(d, 16'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16, 0);
        end

        r0 = rdy_cnt[0];
        ss_n_v[0] = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1; wait_clk(HALF); sclk = 1'b0; wait_clk(HALF);
        end
        rst_n = 1'b0;
        model_reset();
        wait_clk(2);
        check("rst_mid_miso", 32'(miso_v[0]), 32'd0);
        check("rst_mid_rdy", 32'(rdy_v[0]), 32'd0);
        rst_n = 1'b1;
        wait_clk(HALF);
        ss_n_v[0] = 1'b1;
        wait_clk(8);
        check("rst_mid_no_rdy", 32'(rdy_cnt[0] - r0), 32'd0);
        frame(0, 16'h0000, 16, 0);
        check("rst_resync", 32'(last_resp), 32'h0FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
